// File: rtl/sata_pkg.sv
// Shared SATA definitions: FIS type codes, ATA status bit positions and the
// enums used by the register command sequencer.
package sata_pkg;

   localparam logic [7:0] FIS_REG_H2D   = 8'h27;
   localparam logic [7:0] FIS_REG_D2H   = 8'h34;
   localparam logic [7:0] FIS_PIO_SETUP = 8'h5F;

   localparam int unsigned ATA_BSY = 7;
   localparam int unsigned ATA_ERR = 0;

   typedef enum logic [1:0] {
      ResOk      = 2'd0,
      ResDevErr  = 2'd1,
      ResTimeout = 2'd2,
      ResLinkErr = 2'd3
   } sata_cmd_res_t;

   typedef enum logic [2:0] {
      StIdle,
      StSend,
      StTxWait,
      StRxWait,
      StDone
   } sata_seq_state_t;

   typedef struct packed {
      logic [7:0]  command;
      logic [15:0] features;
      logic [47:0] address;
      logic [15:0] scount;
      logic [7:0]  device;
      logic [7:0]  control;
   } sata_h2d_cmd_t;

endpackage

// File: rtl/sata_reg_cmd_sequencer_if.sv
// Command, transmit, register-receive and result signals of the sequencer.
// master is the sequencer's view; slave is the command layer / transport view.
interface sata_reg_cmd_sequencer_if;

   logic [7:0]  cmd_command;
   logic [15:0] cmd_features;
   logic [47:0] cmd_address;
   logic [15:0] cmd_scount;
   logic [7:0]  cmd_device;
   logic [7:0]  cmd_control;
   logic        cmd_val;
   logic        cmd_rdy;

   logic [31:0] tx_dat;
   logic        tx_val;
   logic        tx_eop;
   logic        tx_rdy;
   logic        tx_stat_val;
   logic        tx_stat_err;

   logic [7:0]  rx_type;
   logic [7:0]  rx_status;
   logic [7:0]  rx_error;
   logic        rx_badcrc;
   logic        rx_val;

   logic [7:0]  res_status;
   logic [7:0]  res_error;
   logic [1:0]  res_code;
   logic        res_pio;
   logic        res_val;
   logic        busy;

   modport master (
      input  cmd_command, cmd_features, cmd_address, cmd_scount, cmd_device, cmd_control,
      input  cmd_val, tx_rdy, tx_stat_val, tx_stat_err,
      input  rx_type, rx_status, rx_error, rx_badcrc, rx_val,
      output cmd_rdy, tx_dat, tx_val, tx_eop,
      output res_status, res_error, res_code, res_pio, res_val, busy
   );

   modport slave (
      output cmd_command, cmd_features, cmd_address, cmd_scount, cmd_device, cmd_control,
      output cmd_val, tx_rdy, tx_stat_val, tx_stat_err,
      output rx_type, rx_status, rx_error, rx_badcrc, rx_val,
      input  cmd_rdy, tx_dat, tx_val, tx_eop,
      input  res_status, res_error, res_code, res_pio, res_val, busy
   );

endinterface

// File: rtl/sata_reg_fis_packer.sv
// Selects one dword of a Host-to-Device Register FIS from the latched command
// fields; word 4 is the final (all-zero) dword.
module sata_reg_fis_packer
   import sata_pkg::*;
(
   input  sata_h2d_cmd_t cmd,
   input  logic [2:0]    word_idx,
   output logic [31:0]   dat,
   output logic          eop
);

   always_comb begin
      dat = '0;
      eop = 1'b0;
      case (word_idx)
         3'd0: dat = {cmd.features[7:0], cmd.command, 8'h80, FIS_REG_H2D};
         3'd1: dat = {cmd.device, cmd.address[23:0]};
         3'd2: dat = {cmd.features[15:8], cmd.address[47:24]};
         3'd3: dat = {cmd.control, 8'h00, cmd.scount};
         3'd4: eop = 1'b1;
         default: ;
      endcase
   end

endmodule

// File: rtl/sata_reg_cmd_sequencer.sv
// Issues one ATA non-data/PIO command as a Register H2D FIS, retries on link
// transmit errors and waits (with timeout) for the device's D2H or PIO Setup FIS.
module sata_reg_cmd_sequencer
   import sata_pkg::*;
#(
   parameter int unsigned TIMEOUT_CYCLES = 1000000,
   parameter int unsigned MAX_RETRY      = 3
) (
   input logic                      clk,
   input logic                      reset_n,
   sata_reg_cmd_sequencer_if.master bus
);

   localparam int unsigned       TimerW    = $clog2(TIMEOUT_CYCLES + 1);
   localparam int unsigned       RetryW    = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
   localparam logic [TimerW-1:0] TimerLoad = TimerW'(TIMEOUT_CYCLES - 1);

   sata_seq_state_t   state_q, state_d;
   sata_h2d_cmd_t     cmd_q;
   logic              cmd_load;
   logic [2:0]        idx_q, idx_d;
   logic [RetryW-1:0] retry_q, retry_d;
   logic [TimerW-1:0] timer_q, timer_d;

   logic              res_load;
   sata_cmd_res_t     res_code_q, res_code_d;
   logic [7:0]        res_status_q, res_status_d;
   logic [7:0]        res_error_q, res_error_d;
   logic              res_pio_q, res_pio_d;

   logic              rx_good, rx_d2h_done, rx_pio_done, timer_zero;
   logic [31:0]       fis_dat;
   logic              fis_eop;

   sata_reg_fis_packer u_packer (
      .cmd      (cmd_q),
      .word_idx (idx_q),
      .dat      (fis_dat),
      .eop      (fis_eop)
   );

   assign rx_good     = bus.rx_val & ~bus.rx_badcrc;
   // A D2H with BSY still set is an interim status, not the completion.
   assign rx_d2h_done = rx_good & (bus.rx_type == FIS_REG_D2H) & ~bus.rx_status[ATA_BSY];
   assign rx_pio_done = rx_good & (bus.rx_type == FIS_PIO_SETUP);
   assign timer_zero  = (timer_q == '0);

   always_comb begin
      state_d      = state_q;
      idx_d        = idx_q;
      retry_d      = retry_q;
      timer_d      = timer_zero ? timer_q : timer_q - TimerW'(1);
      cmd_load     = 1'b0;
      res_load     = 1'b0;
      res_code_d   = ResOk;
      res_status_d = '0;
      res_error_d  = '0;
      res_pio_d    = 1'b0;

      unique case (state_q)
         StIdle: begin
            if (bus.cmd_val) begin
               cmd_load = 1'b1;
               retry_d  = '0;
               idx_d    = '0;
               state_d  = StSend;
            end
         end
         StSend: begin
            if (bus.tx_rdy) begin
               if (idx_q == 3'd4) begin
                  timer_d = TimerLoad;
                  state_d = StTxWait;
               end else begin
                  idx_d = idx_q + 3'd1;
               end
            end
         end
         StTxWait: begin
            // Transmit status takes priority over a simultaneous expiry.
            if (bus.tx_stat_val && !bus.tx_stat_err) begin
               timer_d = TimerLoad;
               state_d = StRxWait;
            end else if (bus.tx_stat_val) begin
               if (32'(retry_q) < MAX_RETRY) begin
                  retry_d = retry_q + RetryW'(1);
                  idx_d   = '0;
                  state_d = StSend;
               end else begin
                  res_load   = 1'b1;
                  res_code_d = ResLinkErr;
                  state_d    = StDone;
               end
            end else if (timer_zero) begin
               res_load   = 1'b1;
               res_code_d = ResTimeout;
               state_d    = StDone;
            end
         end
         StRxWait: begin
            if (rx_d2h_done || rx_pio_done) begin
               res_load     = 1'b1;
               res_code_d   = bus.rx_status[ATA_ERR] ? ResDevErr : ResOk;
               res_status_d = bus.rx_status;
               res_error_d  = bus.rx_error;
               res_pio_d    = rx_pio_done;
               state_d      = StDone;
            end else if (timer_zero) begin
               res_load   = 1'b1;
               res_code_d = ResTimeout;
               state_d    = StDone;
            end
         end
         StDone: state_d = StIdle;
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q      <= StIdle;
         cmd_q        <= '0;
         idx_q        <= '0;
         retry_q      <= '0;
         timer_q      <= '0;
         res_code_q   <= ResOk;
         res_status_q <= '0;
         res_error_q  <= '0;
         res_pio_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         retry_q <= retry_d;
         timer_q <= timer_d;
         if (cmd_load) begin
            cmd_q <= '{command:  bus.cmd_command,
                       features: bus.cmd_features,
                       address:  bus.cmd_address,
                       scount:   bus.cmd_scount,
                       device:   bus.cmd_device,
                       control:  bus.cmd_control};
         end
         if (res_load) begin
            res_code_q   <= res_code_d;
            res_status_q <= res_status_d;
            res_error_q  <= res_error_d;
            res_pio_q    <= res_pio_d;
         end
      end
   end

   assign bus.cmd_rdy    = (state_q == StIdle);
   assign bus.tx_val     = (state_q == StSend);
   assign bus.tx_dat     = bus.tx_val ? fis_dat : '0;
   assign bus.tx_eop     = bus.tx_val & fis_eop;
   assign bus.res_val    = (state_q == StDone);
   assign bus.busy       = (state_q != StIdle);
   assign bus.res_code   = res_code_q;
   assign bus.res_status = res_status_q;
   assign bus.res_error  = res_error_q;
   assign bus.res_pio    = res_pio_q;

endmodule

// File: tb/tb_sata_reg_cmd_sequencer.sv
// Scoreboard bench: stimulus queues the expected FIS dwords and results from a
// byte-level FIS model; a negedge monitor pops and compares what the DUT emits.
module tb_sata_reg_cmd_sequencer;
   import sata_pkg::*;

   localparam int MaxRetry = 3;
   localparam int Timeout  = 16;

   typedef struct {
      logic [1:0] code;
      logic [7:0] status;
      logic [7:0] error;
      logic       pio;
      bit         chk_fields;
      int         cyc;
   } exp_res_t;

   logic clk;
   logic reset_n;
   int   cyc;
   int   checks;
   int   errors;
   int   fis_cnt;
   int   acc_in_fis;
   int   stall_left;
   bit   bp_rand;

   logic [32:0] exp_dw[$];
   exp_res_t    exp_res[$];

   sata_reg_cmd_sequencer_if bus ();

   sata_reg_cmd_sequencer #(
      .TIMEOUT_CYCLES (Timeout),
      .MAX_RETRY      (MaxRetry)
   ) dut (
      .clk     (clk),
      .reset_n (reset_n),
      .bus     (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;
   initial cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Reference FIS: 20 bytes laid out as on the wire, packed little-endian into dwords.
   function automatic void push_fis(input sata_h2d_cmd_t c);
      logic [7:0] b[20];
      for (int i = 0; i < 20; i++) b[i] = 8'h00;
      b[0]  = 8'h27;                b[1]  = 8'h80;
      b[2]  = c.command;            b[3]  = c.features[7:0];
      b[4]  = c.address[7:0];       b[5]  = c.address[15:8];
      b[6]  = c.address[23:16];     b[7]  = c.device;
      b[8]  = c.address[31:24];     b[9]  = c.address[39:32];
      b[10] = c.address[47:40];     b[11] = c.features[15:8];
      b[12] = c.scount[7:0];        b[13] = c.scount[15:8];
      b[15] = c.control;
      for (int i = 0; i < 5; i++)
         exp_dw.push_back({i == 4, b[4*i+3], b[4*i+2], b[4*i+1], b[4*i]});
   endfunction

   function automatic void push_res(input logic [1:0] code, input logic [7:0] st,
                                    input logic [7:0] er, input logic pio,
                                    input bit chk_fields, input int at);
      exp_res_t e;
      e.code = code; e.status = st; e.error = er; e.pio = pio;
      e.chk_fields = chk_fields; e.cyc = at;
      exp_res.push_back(e);
   endfunction

   function automatic sata_h2d_cmd_t rand_cmd();
      sata_h2d_cmd_t c;
      c.command  = 8'($urandom);
      c.features = 16'($urandom);
      c.address  = {16'($urandom), 32'($urandom)};
      c.scount   = 16'($urandom);
      c.device   = 8'($urandom);
      c.control  = 8'($urandom);
      return c;
   endfunction

   // tx_rdy: directed 3-cycle stall at DW2, optional random backpressure
   initial begin
      bus.tx_rdy = 1'b1;
      forever begin
         tick();
         if (stall_left > 0 && acc_in_fis == 2 && bus.tx_val) begin
            bus.tx_rdy = 1'b0;
            stall_left--;
         end else begin
            bus.tx_rdy = bp_rand ? ($urandom_range(0, 3) != 0) : 1'b1;
         end
      end
   end

   // Monitor / scoreboard
   initial begin
      bit          hold;
      bit          rdy_chk;
      logic [32:0] held;
      logic [32:0] e;
      exp_res_t    r;
      hold = 0; rdy_chk = 0; held = '0;
      forever begin
         @(negedge clk);
         if (!reset_n) begin
            hold = 0; rdy_chk = 0; acc_in_fis = 0;
         end else begin
            if (hold) begin
               chk("tx_hold_val", bus.tx_val, 1);
               chk("tx_hold_dat", {bus.tx_eop, bus.tx_dat}, held);
            end
            hold = bus.tx_val && !bus.tx_rdy;
            held = {bus.tx_eop, bus.tx_dat};
            if (bus.tx_val && bus.tx_rdy) begin
               if (exp_dw.size() == 0) begin
                  chk("tx_unexpected", bus.tx_val, 0);
               end else begin
                  e = exp_dw.pop_front();
                  chk("tx_dword", {bus.tx_eop, bus.tx_dat}, e);
               end
               acc_in_fis++;
               if (bus.tx_eop) begin
                  fis_cnt++;
                  acc_in_fis = 0;
               end
            end
            if (rdy_chk) begin
               chk("cmd_rdy_after_done", bus.cmd_rdy, 1);
               chk("busy_after_done", bus.busy, 0);
               rdy_chk = 0;
            end
            if (bus.res_val) begin
               if (exp_res.size() == 0) begin
                  chk("res_unexpected", bus.res_val, 0);
               end else begin
                  r = exp_res.pop_front();
                  chk("res_code", bus.res_code, r.code);
                  chk("res_pio", bus.res_pio, r.pio);
                  if (r.chk_fields) begin
                     chk("res_status", bus.res_status, r.status);
                     chk("res_error", bus.res_error, r.error);
                  end
                  if (r.cyc >= 0) chk("res_cycle", cyc, r.cyc);
                  chk("busy_in_done", bus.busy, 1);
                  rdy_chk = 1;
               end
            end
         end
      end
   end

   task automatic issue(input sata_h2d_cmd_t c, input bit stray);
      int n = 0;
      while (!bus.cmd_rdy && n < 300) begin
         tick();
         n++;
      end
      bus.cmd_command = c.command;  bus.cmd_features = c.features;
      bus.cmd_address = c.address;  bus.cmd_scount   = c.scount;
      bus.cmd_device  = c.device;   bus.cmd_control  = c.control;
      bus.cmd_val = 1'b1;
      tick();
      bus.cmd_val = 1'b0;
      chk("dw0_next_cycle", bus.tx_val, 1);
      // Scramble the fields: the DUT must use its latched copy.
      bus.cmd_command = 8'($urandom); bus.cmd_address = {16'($urandom), 32'($urandom)};
      if (stray) begin
         bus.rx_type = FIS_REG_D2H; bus.rx_status = 8'h50; bus.rx_badcrc = 1'b0;
         bus.rx_val = 1'b1; bus.tx_stat_val = 1'b1; bus.tx_stat_err = 1'b0;
         tick();
         bus.rx_val = 1'b0; bus.tx_stat_val = 1'b0;
      end
   endtask

   task automatic pulse_rx(input logic [7:0] t, input logic [7:0] st, input logic [7:0] er,
                           input logic badcrc);
      bus.rx_type = t; bus.rx_status = st; bus.rx_error = er; bus.rx_badcrc = badcrc;
      bus.rx_val = 1'b1;
      tick();
      bus.rx_val = 1'b0; bus.rx_badcrc = 1'b0;
   endtask

   task automatic wait_fis(input int target);
      int n = 0;
      while (fis_cnt < target && n < 300) begin
         tick();
         n++;
      end
      if (fis_cnt < target) chk("fis_wait", fis_cnt, target);
   endtask

   task automatic wait_res();
      int n = 0;
      while (exp_res.size() != 0 && n < 100) begin
         tick();
         n++;
      end
      if (exp_res.size() != 0) begin
         chk("res_wait", exp_res.size(), 0);
         exp_res.delete();
      end
      tick();
      tick();
   endtask

   // kind: 0 D2H completion, 1 PIO Setup, 2 no response, 3 D2H on the expiry cycle
   task automatic run_cmd(input sata_h2d_cmd_t c, input int n_err, input int kind,
                          input logic [7:0] st, input logic [7:0] er, input int n_junk,
                          input bit stray);
      int         att, base, c_ok;
      logic [7:0] jt;
      att  = (n_err > MaxRetry) ? MaxRetry + 1 : n_err + 1;
      base = fis_cnt;
      c_ok = 0;
      for (int a = 0; a < att; a++) push_fis(c);
      issue(c, stray);
      for (int a = 0; a < att; a++) begin
         wait_fis(base + a + 1);
         repeat ($urandom_range(0, 3)) tick();
         bus.tx_stat_val = 1'b1;
         bus.tx_stat_err = (a < n_err);
         if (a < n_err && a == att - 1) push_res(2'd3, 8'h00, 8'h00, 1'b0, 0, cyc + 1);
         c_ok = cyc;
         tick();
         bus.tx_stat_val = 1'b0;
         bus.tx_stat_err = 1'b0;
      end
      if (n_err <= MaxRetry) begin
         for (int j = 0; j < n_junk; j++) begin
            case (j % 3)
               0: pulse_rx(FIS_REG_D2H, 8'($urandom) | 8'h80, 8'($urandom), 1'b0);
               1: pulse_rx(($urandom_range(0, 1) != 0) ? FIS_REG_D2H : FIS_PIO_SETUP,
                           8'($urandom) & 8'h7F, 8'($urandom), 1'b1);
               default: begin
                  jt = 8'($urandom);
                  if (jt == FIS_REG_D2H || jt == FIS_PIO_SETUP) jt = 8'h46;
                  pulse_rx(jt, 8'($urandom) & 8'h7F, 8'($urandom), 1'b0);
               end
            endcase
            tick();
         end
         case (kind)
            0: begin
               push_res({1'b0, st[0]}, st, er, 1'b0, 1, cyc + 1);
               pulse_rx(FIS_REG_D2H, st, er, 1'b0);
            end
            1: begin
               push_res({1'b0, st[0]}, st, er, 1'b1, 1, cyc + 1);
               pulse_rx(FIS_PIO_SETUP, st, er, 1'b0);
            end
            2: push_res(2'd2, 8'h00, 8'h00, 1'b0, 1, c_ok + Timeout + 1);
            default: begin
               while (cyc < c_ok + Timeout) tick();
               push_res({1'b0, st[0]}, st, er, 1'b0, 1, cyc + 1);
               pulse_rx(FIS_REG_D2H, st, er, 1'b0);
            end
         endcase
      end
      wait_res();
   endtask

   initial begin
      sata_h2d_cmd_t c;
      int            kind;
      logic [7:0]    st;
      checks = 0; errors = 0; fis_cnt = 0; acc_in_fis = 0; stall_left = 0; bp_rand = 0;
      reset_n = 1'b0;
      bus.cmd_val = 1'b0; bus.cmd_command = '0; bus.cmd_features = '0; bus.cmd_address = '0;
      bus.cmd_scount = '0; bus.cmd_device = '0; bus.cmd_control = '0;
      bus.tx_stat_val = 1'b0; bus.tx_stat_err = 1'b0;
      bus.rx_val = 1'b0; bus.rx_badcrc = 1'b0; bus.rx_type = '0;
      bus.rx_status = '0; bus.rx_error = '0;
      repeat (2) tick();
      chk("rst_cmd_rdy", bus.cmd_rdy, 1);
      chk("rst_tx_val", bus.tx_val, 0);
      chk("rst_busy", bus.busy, 0);
      chk("rst_res_val", bus.res_val, 0);
      chk("rst_res_fields", {bus.res_code, bus.res_status, bus.res_error, bus.res_pio}, 0);
      reset_n = 1'b1;
      tick();

      // Basic IDENTIFY-style command
      c = '{command: 8'hEC, features: 16'h0, address: 48'h0, scount: 16'h1,
            device: 8'hA0, control: 8'h00};
      run_cmd(c, 0, 0, 8'h50, 8'h00, 0, 0);

      // Backpressure: three stall cycles on DW2
      stall_left = 3;
      run_cmd(rand_cmd(), 0, 0, 8'h50, 8'h00, 0, 0);
      chk("stall_consumed", stall_left, 0);

      // Retries exhausted, then recovered after two errors
      run_cmd(rand_cmd(), 4, 0, 8'h50, 8'h00, 0, 0);
      run_cmd(rand_cmd(), 2, 0, 8'h50, 8'h00, 0, 0);

      // BSY D2H, bad CRC and foreign FIS are ignored; PIO Setup completes
      run_cmd(rand_cmd(), 0, 1, 8'h58, 8'h00, 3, 0);
      run_cmd(rand_cmd(), 0, 0, 8'h51, 8'h04, 0, 0);

      // Reset while sending
      c = rand_cmd();
      push_fis(c);
      issue(c, 0);
      tick();
      reset_n = 1'b0;
      #1;
      chk("midrst_tx_val", bus.tx_val, 0);
      chk("midrst_busy", bus.busy, 0);
      chk("midrst_cmd_rdy", bus.cmd_rdy, 1);
      chk("midrst_res_val", bus.res_val, 0);
      chk("midrst_res_fields", {bus.res_code, bus.res_status, bus.res_error}, 0);
      exp_dw.delete();
      repeat (2) tick();
      reset_n = 1'b1;
      repeat (20) tick();
      run_cmd(rand_cmd(), 0, 0, 8'h40, 8'h00, 0, 0);

      // Timeout, and a response landing on the expiry cycle
      run_cmd(rand_cmd(), 0, 2, 8'h00, 8'h00, 0, 0);
      run_cmd(rand_cmd(), 0, 3, 8'h50, 8'h00, 0, 0);

      // Randomized commands
      for (int i = 0; i < 24; i++) begin
         bp_rand    = ($urandom_range(0, 1) != 0);
         stall_left = ($urandom_range(0, 3) == 0) ? 3 : 0;
         kind       = $urandom_range(0, 3);
         st         = 8'($urandom);
         if (kind != 1) st[7] = 1'b0;
         run_cmd(rand_cmd(), $urandom_range(0, 4), kind, st, 8'($urandom),
                 $urandom_range(0, 3), ($urandom_range(0, 3) == 0));
         stall_left = 0;
      end
      bp_rand = 0;

      repeat (5) tick();
      chk("dw_left", exp_dw.size(), 0);
      chk("res_left", exp_res.size(), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
      $fatal(1, "watchdog");
   end

endmodule
